// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM arbiter slice.
package vram_pkg;

   localparam int unsigned FB_W       = 160;
   localparam int unsigned FB_H       = 120;
   localparam int unsigned FB_DEPTH   = 19200;
   localparam int unsigned SCALE_LOG2 = 2;
   localparam int unsigned PIPE_DLY   = 3;

   localparam int unsigned PIX_DW = 12;
   localparam int unsigned FB_AW  = 15;

   typedef logic [PIX_DW-1:0] pixel_t;
   typedef logic [FB_AW-1:0]  fb_addr_t;

   // Identity of the writer that most recently won the RAM port.
   typedef enum logic {
      WR0 = 1'b0,
      WR1 = 1'b1
   } wr_sel_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted writer.
import vram_pkg::*;

module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] elig_i,
   output logic [1:0] grant_o
);

   wr_sel_e last_q, last_d;

   // Grant the eligible writer that did not win last; move pointer only on a grant.
   always_comb begin
      grant_o = '0;
      last_d  = last_q;
      if (en_i) begin
         unique case (elig_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == WR1) ? 2'b01 : 2'b10;
            default: grant_o = '0;
         endcase
      end
      if (grant_o[0]) last_d = WR0;
      if (grant_o[1]) last_d = WR1;
   end

   // Pointer register; resets to writer 1 so writer 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= WR1;
      else     last_q <= last_d;
   end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM port owner: scan-out reads on slot cycles, round-robin writes otherwise,
// with hs/vs/pix_v realigned to the returned pixel.
// Optional: define VRAM_ARB_VBLANK_ONLY_EN to restrict writes to pix_y >= 480.
import vram_pkg::*;

module vram_arbiter #(
   parameter int pA = 10,
   parameter int AW = 15,
   parameter int DW = 12
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [pA-1:0]   pix_x,
   input  logic [pA-1:0]   pix_y,
   input  logic            pix_v,
   input  logic            hs_in,
   input  logic            vs_in,
   input  logic [1:0]      wr_req,
   input  logic [2*AW-1:0] wr_addr,
   input  logic [2*DW-1:0] wr_data,
   output logic [1:0]      wr_ack,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_we,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   output logic [DW-1:0]   rgb,
   output logic            hs,
   output logic            vs,
   output logic            pix_v_o
);

   logic                   slot;
   logic                   wr_en;
   logic [AW-1:0]          rd_addr;
   logic [1:0]             elig;
   logic [1:0]             grant;
   logic [pA-SCALE_LOG2-1:0] ys, xs;

   logic [AW-1:0]          mem_addr_q, mem_addr_d;
   logic                   mem_we_q, mem_we_d;
   logic [DW-1:0]          mem_wdata_q, mem_wdata_d;
   logic [1:0]             ack_q, ack_d;

   logic [PIPE_DLY-2:0]    slot_q;
   logic [PIPE_DLY-1:0]    hs_q, vs_q, pv_q;
   logic [DW-1:0]          pix_q;

   // Slot decode, read address (y*160 as (y<<7)+(y<<5)) and writer eligibility.
   always_comb begin
      slot    = pix_v && (pix_x[SCALE_LOG2-1:0] == '0);
      ys      = pix_y[pA-1:SCALE_LOG2];
      xs      = pix_x[pA-1:SCALE_LOG2];
      rd_addr = AW'({ys, 7'b0}) + AW'({ys, 5'b0}) + AW'(xs);
      elig    = wr_req & ~ack_q;
`ifdef VRAM_ARB_VBLANK_ONLY_EN
      wr_en   = !slot && (pix_y >= pA'(480));
`else
      wr_en   = !slot;
`endif
   end

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .en_i    (wr_en),
      .elig_i  (elig),
      .grant_o (grant)
   );

   // Next RAM port value: scan read, granted write, or idle (address held).
   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      ack_d       = '0;
      if (slot) begin
         mem_addr_d = rd_addr;
      end else if (grant[0]) begin
         mem_addr_d  = wr_addr[AW-1:0];
         mem_wdata_d = wr_data[DW-1:0];
         mem_we_d    = (wr_addr[AW-1:0] < AW'(FB_DEPTH));
         ack_d       = 2'b01;
      end else if (grant[1]) begin
         mem_addr_d  = wr_addr[2*AW-1:AW];
         mem_wdata_d = wr_data[2*DW-1:DW];
         mem_we_d    = (wr_addr[2*AW-1:AW] < AW'(FB_DEPTH));
         ack_d       = 2'b10;
      end
   end

   // Registered RAM port and write acknowledges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         ack_q       <= '0;
      end else begin
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         ack_q       <= ack_d;
      end
   end

   // Three-stage sync pipeline; pixel register loads only when a scan read returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
         hs_q   <= '1;
         vs_q   <= '1;
         pv_q   <= '0;
         pix_q  <= '0;
      end else begin
         slot_q <= {slot_q[0], slot};
         hs_q   <= {hs_q[PIPE_DLY-2:0], hs_in};
         vs_q   <= {vs_q[PIPE_DLY-2:0], vs_in};
         pv_q   <= {pv_q[PIPE_DLY-2:0], pix_v};
         if (slot_q[1]) pix_q <= mem_rdata;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign wr_ack    = ack_q;
   assign hs        = hs_q[PIPE_DLY-1];
   assign vs        = vs_q[PIPE_DLY-1];
   assign pix_v_o   = pv_q[PIPE_DLY-1];
   assign rgb       = pix_v_o ? pix_q : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural sync RAM.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  pix_x = '0, pix_y = '0;
   logic        pix_v = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
   logic [1:0]  wr_req = '0;
   logic [29:0] wr_addr = '0;
   logic [23:0] wr_data = '0;
   logic [1:0]  wr_ack;
   logic [14:0] mem_addr;
   logic        mem_we;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata = '0;
   logic [11:0] rgb;
   logic        hs, vs, pix_v_o;

   logic [11:0] ram [0:19199];
   logic        pre_we = 1'b0;
   logic [14:0] pre_addr = '0;
   logic [11:0] pre_data = '0;

   int errs = 0;
   int checks = 0;

`ifdef VRAM_ARB_VBLANK_ONLY_EN
   localparam logic [9:0] WR_Y = 10'd480;
`else
   localparam logic [9:0] WR_Y = 10'd0;
`endif

   vram_arbiter #(.pA(10), .AW(15), .DW(12)) dut (
      .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_v(pix_v),
      .hs_in(hs_in), .vs_in(vs_in), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ack(wr_ack), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rgb(rgb), .hs(hs),
      .vs(vs), .pix_v_o(pix_v_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we) ram[pre_addr] <= pre_data;
      else if (mem_we && mem_addr < 15'd19200) ram[mem_addr] <= mem_wdata;
      mem_rdata <= (mem_addr < 15'd19200) ? ram[mem_addr] : 12'h000;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [14:0] a, input logic [11:0] d);
      pre_addr = a; pre_data = d; pre_we = 1'b1;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      preload(15'd161, 12'hABC);
      preload(15'd162, 12'h123);
      preload(15'd320, 12'h5A5);
      checks++; if (hs !== 1'b1 || vs !== 1'b1) begin errs++; $display("FAIL rst_sync got hs=%b vs=%b exp 1 1", hs, vs); end
      checks++; if (rgb !== 12'h000 || pix_v_o !== 1'b0) begin errs++; $display("FAIL rst_pix got rgb=%h pv=%b exp 000 0", rgb, pix_v_o); end
      checks++; if (mem_we !== 1'b0 || wr_ack !== 2'b00 || mem_addr !== 15'd0) begin errs++; $display("FAIL rst_port got we=%b ack=%b addr=%0d exp 0 00 0", mem_we, wr_ack, mem_addr); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_alternate();
      logic [1:0] exp_ack;
      logic [14:0] exp_addr;
      pix_v = 1'b0; pix_x = 10'd1; pix_y = WR_Y;
      wr_addr = {15'd200, 15'd100};
      wr_data = {12'h222, 12'h111};
      wr_req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         tick();
         exp_ack  = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (k % 2 == 0) ? 15'd100 : 15'd200;
         checks++; if (wr_ack !== exp_ack || mem_we !== 1'b1 || mem_addr !== exp_addr) begin
            errs++; $display("FAIL alt_grant%0d got ack=%b we=%b addr=%0d exp %b 1 %0d", k, wr_ack, mem_we, mem_addr, exp_ack, exp_addr);
         end
      end
      wr_req = 2'b00;
      tick();
      checks++; if (mem_we !== 1'b0 || wr_ack !== 2'b00 || mem_addr !== 15'd200) begin errs++; $display("FAIL idle_hold got we=%b ack=%b addr=%0d exp 0 00 200", mem_we, wr_ack, mem_addr); end
      checks++; if (ram[100] !== 12'h111 || ram[200] !== 12'h222) begin errs++; $display("FAIL alt_data got %h %h exp 111 222", ram[100], ram[200]); end
   endtask

   task automatic test_scan();
      pix_v = 1'b1; pix_y = 10'd4; wr_req = 2'b00;
      for (int k = 0; k < 8; k++) begin
         pix_x = 10'(4 + k);
         hs_in = (k == 0) ? 1'b0 : 1'b1;
         vs_in = (k == 0) ? 1'b0 : 1'b1;
         tick();
         if (k == 0) begin
            checks++; if (mem_addr !== 15'd161 || mem_we !== 1'b0) begin errs++; $display("FAIL scan_addr got addr=%0d we=%b exp 161 0", mem_addr, mem_we); end
         end
         if (k == 1 || k == 3) begin
            checks++; if (hs !== 1'b1) begin errs++; $display("FAIL hs_idle%0d got %b exp 1", k, hs); end
         end
         if (k == 2) begin
            checks++; if (hs !== 1'b0 || vs !== 1'b0 || pix_v_o !== 1'b1) begin errs++; $display("FAIL sync_align got hs=%b vs=%b pv=%b exp 0 0 1", hs, vs, pix_v_o); end
         end
         if (k >= 2 && k <= 5) begin
            checks++; if (rgb !== 12'hABC) begin errs++; $display("FAIL scan_rep%0d got %h exp abc", k, rgb); end
         end
         if (k == 6) begin
            checks++; if (rgb !== 12'h123) begin errs++; $display("FAIL scan_next got %h exp 123", rgb); end
         end
      end
      pix_v = 1'b0;
      tick(); tick(); tick();
      checks++; if (rgb !== 12'h000 || pix_v_o !== 1'b0) begin errs++; $display("FAIL blank_rgb got rgb=%h pv=%b exp 000 0", rgb, pix_v_o); end
   endtask

   task automatic test_slot_conflict();
`ifndef VRAM_ARB_VBLANK_ONLY_EN
      pix_v = 1'b1; pix_x = 10'd0; pix_y = 10'd8;
      wr_addr = {15'd0, 15'd300}; wr_data = {12'h000, 12'h0F0};
      wr_req = 2'b01;
      tick();
      checks++; if (wr_ack !== 2'b00 || mem_addr !== 15'd320 || mem_we !== 1'b0) begin errs++; $display("FAIL slot_block got ack=%b addr=%0d we=%b exp 00 320 0", wr_ack, mem_addr, mem_we); end
      pix_x = 10'd1;
      tick();
      checks++; if (wr_ack !== 2'b01 || mem_we !== 1'b1 || mem_addr !== 15'd300 || mem_wdata !== 12'h0F0) begin
         errs++; $display("FAIL slot_after got ack=%b we=%b addr=%0d data=%h exp 01 1 300 0f0", wr_ack, mem_we, mem_addr, mem_wdata);
      end
      wr_req = 2'b00; pix_x = 10'd2;
      tick();
      pix_x = 10'd3;
      checks++; if (rgb !== 12'h5A5) begin errs++; $display("FAIL slot_read got %h exp 5a5", rgb); end
      tick();
      pix_v = 1'b0;
      tick(); tick(); tick();
`endif
   endtask

   task automatic test_out_of_range();
      pix_v = 1'b0; pix_x = 10'd1; pix_y = WR_Y;
      wr_addr = {15'd0, 15'd19200}; wr_data = {12'h000, 12'hFFF};
      wr_req = 2'b01;
      tick();
      checks++; if (wr_ack !== 2'b01 || mem_we !== 1'b0) begin errs++; $display("FAIL oor_drop got ack=%b we=%b exp 01 0", wr_ack, mem_we); end
      wr_req = 2'b00;
      tick();
      wr_addr = {15'd0, 15'd19199}; wr_data = {12'h000, 12'h7E7};
      wr_req = 2'b01;
      tick();
      checks++; if (wr_ack !== 2'b01 || mem_we !== 1'b1 || mem_addr !== 15'd19199) begin errs++; $display("FAIL last_addr got ack=%b we=%b addr=%0d exp 01 1 19199", wr_ack, mem_we, mem_addr); end
      wr_req = 2'b00;
      tick();
      checks++; if (ram[19199] !== 12'h7E7) begin errs++; $display("FAIL last_data got %h exp 7e7", ram[19199]); end
   endtask

   task automatic test_vblank();
      pix_v = 1'b0; pix_x = 10'd1; pix_y = 10'd100;
      wr_addr = {15'd0, 15'd50}; wr_data = {12'h000, 12'h050};
      wr_req = 2'b01;
`ifdef VRAM_ARB_VBLANK_ONLY_EN
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (wr_ack !== 2'b00) begin errs++; $display("FAIL vb_wait%0d got %b exp 00", k, wr_ack); end
      end
      pix_y = 10'd480;
      tick();
      checks++; if (wr_ack !== 2'b01) begin errs++; $display("FAIL vb_grant got %b exp 01", wr_ack); end
`else
      tick();
      checks++; if (wr_ack !== 2'b01 || mem_addr !== 15'd50) begin errs++; $display("FAIL any_line got ack=%b addr=%0d exp 01 50", wr_ack, mem_addr); end
`endif
      wr_req = 2'b00;
      tick();
   endtask

   task automatic test_reset_mid();
      pix_v = 1'b1; pix_y = 10'd4; hs_in = 1'b0; vs_in = 1'b0;
`ifdef VRAM_ARB_VBLANK_ONLY_EN
      pix_y = 10'd4;
`endif
      wr_addr = {15'd0, 15'd400}; wr_data = {12'h000, 12'h444};
      wr_req = 2'b00;
      for (int k = 0; k < 4; k++) begin
         pix_x = 10'(4 + k);
         if (k == 1) wr_req = 2'b01;
         tick();
      end
      checks++; if (hs !== 1'b0 || rgb !== 12'hABC) begin errs++; $display("FAIL pre_rst got hs=%b rgb=%h exp 0 abc", hs, rgb); end
`ifndef VRAM_ARB_VBLANK_ONLY_EN
      checks++; if (mem_we !== 1'b1 || wr_ack !== 2'b01) begin errs++; $display("FAIL pre_rst_wr got we=%b ack=%b exp 1 01", mem_we, wr_ack); end
`endif
      rst = 1'b1;
      #1;
      checks++; if (hs !== 1'b1 || vs !== 1'b1 || rgb !== 12'h000) begin errs++; $display("FAIL mid_rst_out got hs=%b vs=%b rgb=%h exp 1 1 000", hs, vs, rgb); end
      checks++; if (mem_we !== 1'b0 || wr_ack !== 2'b00 || mem_addr !== 15'd0) begin errs++; $display("FAIL mid_rst_port got we=%b ack=%b addr=%0d exp 0 00 0", mem_we, wr_ack, mem_addr); end
      wr_req = 2'b00; pix_v = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
      pix_x = 10'd1; pix_y = WR_Y;
      tick(); tick();
      rst = 1'b0;
      wr_addr = {15'd600, 15'd500}; wr_data = {12'h666, 12'h555};
      wr_req = 2'b11;
      tick();
      checks++; if (wr_ack !== 2'b01 || mem_addr !== 15'd500) begin errs++; $display("FAIL rr_after_rst got ack=%b addr=%0d exp 01 500", wr_ack, mem_addr); end
      wr_req = 2'b00;
      tick();
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_scan();
      test_slot_conflict();
      test_out_of_range();
      test_vblank();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
